// File: rtl/mlp_result_argmax.sv
`default_nettype none
// ============================================================================
// Module      : mlp_result_argmax
// Description : Snoops the MLP y_buf write stream, keeps a running argmax per
//               image and queues {image, class, score} results in a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_result_argmax #(
    parameter int IN_IMG_NUM       = 10,
    parameter int NUM_CLASS        = 10,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int IMGW             = $clog2(IN_IMG_NUM),
    parameter int CLSW             = $clog2(NUM_CLASS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        y_buf_en_i,
    input  logic                        y_buf_wr_en_i,
    input  logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr_i,
    input  logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data_i,
    output logic                        pred_valid_o,
    input  logic                        pred_ready_i,
    output logic [IMGW-1:0]             pred_img_o,
    output logic [CLSW-1:0]             pred_class_o,
    output logic [Y_BUF_DATA_WIDTH-1:0] pred_score_o,
    output logic                        all_done_o,
    output logic                        err_o
);

    localparam int C_TOTAL = IN_IMG_NUM * NUM_CLASS;
    localparam int C_IDXW  = $clog2(C_TOTAL + 1);
    localparam int C_PTRW  = $clog2(FIFO_DEPTH);
    localparam int C_CNTW  = C_PTRW + 1;
    localparam logic [C_IDXW-1:0] C_LAST_IDX = C_IDXW'(C_TOTAL - 1);
    localparam logic [CLSW-1:0]   C_LAST_CLS = CLSW'(NUM_CLASS - 1);
    localparam logic [C_CNTW-1:0] C_FULL     = C_CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [C_IDXW-1:0]           r_exp_idx;
    logic [IMGW-1:0]             r_img_cnt;
    logic [CLSW-1:0]             r_cls_cnt;
    logic [Y_BUF_DATA_WIDTH-1:0] r_max;
    logic [CLSW-1:0]             r_argcls;
    logic                        r_err;

    logic [IMGW-1:0]             r_fifo_img   [FIFO_DEPTH];
    logic [CLSW-1:0]             r_fifo_cls   [FIFO_DEPTH];
    logic [Y_BUF_DATA_WIDTH-1:0] r_fifo_score [FIFO_DEPTH];
    logic [C_PTRW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [C_CNTW-1:0]           r_count, w_count_next;

    logic                        w_beat, w_addr_ok, w_collect_beat, w_beat_ok, w_beat_bad;
    logic                        w_arm, w_take_new, w_push_req, w_last_beat;
    logic                        w_pop, w_full, w_push, w_overflow;
    logic [Y_BUF_ADDR_WIDTH-1:0] w_index;
    logic [Y_BUF_DATA_WIDTH-1:0] w_win_score;
    logic [CLSW-1:0]             w_win_cls;

    assign w_beat         = y_buf_en_i & y_buf_wr_en_i;
    assign w_index        = y_buf_addr_i >> 2;
    assign w_addr_ok      = (y_buf_addr_i[1:0] == 2'b00) &&
                            (w_index == Y_BUF_ADDR_WIDTH'(r_exp_idx));
    assign w_collect_beat = (r_state == S_COLLECT) && w_beat;
    assign w_beat_ok      = w_collect_beat && w_addr_ok;
    assign w_beat_bad     = w_collect_beat && !w_addr_ok;
    assign w_arm          = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Strict greater-than: on a tie the earlier (lower) class keeps the win.
    assign w_take_new  = (r_cls_cnt == '0) || ($signed(y_buf_data_i) > $signed(r_max));
    assign w_win_score = w_take_new ? y_buf_data_i : r_max;
    assign w_win_cls   = w_take_new ? r_cls_cnt : r_argcls;

    assign w_push_req  = w_beat_ok && (r_cls_cnt == C_LAST_CLS);
    assign w_last_beat = w_beat_ok && (r_exp_idx == C_LAST_IDX);

    assign pred_valid_o = (r_count != '0);
    assign w_pop        = pred_valid_o && pred_ready_i;
    assign w_full       = (r_count == C_FULL);
    // A pop on the same edge frees the slot, so a full FIFO can still take a push.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_overflow   = w_push_req && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + C_CNTW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - C_CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_state_next = S_COLLECT;
            S_COLLECT: if (w_last_beat) w_state_next = S_DRAIN;
            S_DRAIN:   if (w_count_next == '0) w_state_next = S_DONE;
            S_DONE:    if (start_i) w_state_next = S_COLLECT;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exp_idx <= '0;
            r_img_cnt <= '0;
            r_cls_cnt <= '0;
            r_max     <= '0;
            r_argcls  <= '0;
            r_err     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_img[i]   <= '0;
                r_fifo_cls[i]   <= '0;
                r_fifo_score[i] <= '0;
            end
        end else if (w_arm) begin
            r_exp_idx <= '0;
            r_img_cnt <= '0;
            r_cls_cnt <= '0;
            r_err     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_beat_ok) begin
                r_max     <= w_win_score;
                r_argcls  <= w_win_cls;
                r_exp_idx <= r_exp_idx + C_IDXW'(1);
                if (r_cls_cnt == C_LAST_CLS) begin
                    r_cls_cnt <= '0;
                    r_img_cnt <= r_img_cnt + IMGW'(1);
                end else begin
                    r_cls_cnt <= r_cls_cnt + CLSW'(1);
                end
            end
            if (w_beat_bad || w_overflow) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_fifo_img[r_wr_ptr]   <= r_img_cnt;
                r_fifo_cls[r_wr_ptr]   <= w_win_cls;
                r_fifo_score[r_wr_ptr] <= w_win_score;
                r_wr_ptr               <= r_wr_ptr + C_PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTRW'(1);
            end
            r_count <= w_count_next;
        end
    end

    assign pred_img_o   = r_fifo_img[r_rd_ptr];
    assign pred_class_o = r_fifo_cls[r_rd_ptr];
    assign pred_score_o = r_fifo_score[r_rd_ptr];
    assign all_done_o   = (r_state == S_DONE);
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mlp_result_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_result_argmax
// Description : Self-checking bench for mlp_result_argmax with a queue-based
//               reference model of the per-image argmax and result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_result_argmax;

    localparam int IN_IMG_NUM = 10;
    localparam int NUM_CLASS  = 10;
    localparam int DEPTH      = 4;
    localparam int TOTAL      = IN_IMG_NUM * NUM_CLASS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        y_en = 1'b0;
    logic        y_wr = 1'b0;
    logic [31:0] y_addr = '0;
    logic [31:0] y_data = '0;
    logic        y_ready = 1'b0;
    logic        pred_valid;
    logic [3:0]  pred_img;
    logic [3:0]  pred_class;
    logic [31:0] pred_score;
    logic        all_done;
    logic        err;

    mlp_result_argmax dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .y_buf_en_i   (y_en),
        .y_buf_wr_en_i(y_wr),
        .y_buf_addr_i (y_addr),
        .y_buf_data_i (y_data),
        .pred_valid_o (pred_valid),
        .pred_ready_i (y_ready),
        .pred_img_o   (pred_img),
        .pred_class_o (pred_class),
        .pred_score_o (pred_score),
        .all_done_o   (all_done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int img;
        int cls;
        int score;
    } res_t;

    // Reference model state: results the DUT should be holding, in order.
    res_t exp_q[$];
    bit   m_armed = 0;
    bit   m_err   = 0;
    bit   m_done  = 0;
    int   m_exp   = 0;
    int   m_scores[NUM_CLASS];
    bit   p_push, p_err, p_fin;
    res_t p_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("pred_valid", 64'(pred_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("pred_img",   64'(pred_img),   64'(exp_q[0].img));
            chk("pred_class", 64'(pred_class), 64'(exp_q[0].cls));
            chk("pred_score", {32'b0, pred_score}, {32'b0, 32'(exp_q[0].score)});
        end
        chk("err", 64'(err), 64'(m_err));
        chk("all_done", 64'(all_done), 64'(m_done && exp_q.size() == 0));
        if (exp_q.size() != 0 && y_ready) void'(exp_q.pop_front());
    end

    // Evaluated before the edge that samples the beat.
    task automatic model_pre(input logic [31:0] addr, input logic [31:0] data);
        int cls, img, best;
        p_push = 0;
        p_err  = 0;
        p_fin  = 0;
        if (!m_armed) return;
        if (addr[1:0] != 2'b00 || int'(addr >> 2) != m_exp) begin
            p_err = 1;
            return;
        end
        cls = m_exp % NUM_CLASS;
        img = m_exp / NUM_CLASS;
        m_scores[cls] = int'(data);
        m_exp++;
        if (cls == NUM_CLASS - 1) begin
            best = 0;
            for (int c = 1; c < NUM_CLASS; c++)
                if (m_scores[c] > m_scores[best]) best = c;
            p_res = '{img, best, m_scores[best]};
            if (exp_q.size() < DEPTH || y_ready) p_push = 1;
            else p_err = 1;
            if (img == IN_IMG_NUM - 1) begin
                p_fin   = 1;
                m_armed = 0;
            end
        end
    endtask

    task automatic model_post();
        if (p_push) exp_q.push_back(p_res);
        if (p_err)  m_err = 1;
        if (p_fin)  m_done = 1;
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic send(input logic [31:0] addr, input logic [31:0] data);
        y_en = 1'b1; y_wr = 1'b1; y_addr = addr; y_data = data;
        model_pre(addr, data);
        @(posedge clk);
        model_post();
        #1;
        y_en = 1'b0; y_wr = 1'b0;
    endtask

    task automatic send_idx(input int idx, input int data);
        send(32'(idx * 4), 32'(data));
    endtask

    task automatic do_start();
        bit eff;
        eff = !m_armed && (!m_done || exp_q.size() == 0);
        start = 1'b1;
        @(posedge clk);
        if (eff) begin
            exp_q.delete();
            m_err = 0; m_done = 0; m_exp = 0; m_armed = 1;
        end
        #1;
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        y_en = 1'($urandom_range(0, 1));
        y_wr = 1'b0;
        y_addr = $urandom;
        @(posedge clk);
        #1;
        y_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (all_done) break;
        end
        chk(tag, 64'(all_done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 64'(pred_valid), 64'd0);
        chk({tag, "_img"},   64'(pred_img),   64'd0);
        chk({tag, "_class"}, 64'(pred_class), 64'd0);
        chk({tag, "_score"}, {32'b0, pred_score}, 64'd0);
        chk({tag, "_done"},  64'(all_done),   64'd0);
        chk({tag, "_err"},   64'(err),        64'd0);
    endtask

    function automatic int rnd_score();
        case ($urandom_range(0, 2))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 8)) - 4;
            default: return int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic random_beats(input int first, input bit rand_ready);
        for (int idx = first; idx < TOTAL; idx++) begin
            if (rand_ready) y_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle_cycle();
            send_idx(idx, rnd_score());
        end
        y_ready = 1'b1;
    endtask

    initial begin
        int tie[NUM_CLASS];
        tie = '{-3, -1, -1, -7, -9, -20, -5, -2, -8, -100};

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Directed batch: image k wins at class k%10 with 1000+k.
        do_start();
        y_ready = 1'b1;
        for (int k = 0; k < IN_IMG_NUM; k++)
            for (int c = 0; c < NUM_CLASS; c++)
                send_idx(k * NUM_CLASS + c, (c == k % 10) ? 1000 + k : -5);
        wait_done("directed_done");

        // Negative scores with a tie at classes 1 and 2.
        do_start();
        y_ready = 1'b0;
        for (int c = 0; c < NUM_CLASS; c++) send_idx(c, tie[c]);
        @(negedge clk);
        chk("tie_valid", 64'(pred_valid), 64'd1);
        chk("tie_img",   64'(pred_img),   64'd0);
        chk("tie_class", 64'(pred_class), 64'd1);
        chk("tie_score", {32'b0, pred_score}, {32'b0, 32'hFFFF_FFFF});
        @(posedge clk);
        #1;
        y_ready = 1'b1;
        random_beats(NUM_CLASS, 1'b0);
        wait_done("tie_done");

        // Consumer stalled for the whole batch: overflow.
        do_start();
        y_ready = 1'b0;
        random_beats(0, 1'b0);
        y_ready = 1'b0;
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_head_img", 64'(pred_img), 64'd0);
        chk("ovf_valid", 64'(pred_valid), 64'd1);
        y_ready = 1'b1;
        wait_done("ovf_done");

        // Misaligned and out-of-order beats are dropped.
        do_start();
        y_ready = 1'b1;
        send(32'h0, 32'(rnd_score()));
        send(32'h8, 32'(rnd_score()));
        chk("bad_idx_err", 64'(err), 64'd1);
        send(32'h6, 32'(rnd_score()));
        send(32'h4, 32'(rnd_score()));
        random_beats(2, 1'b0);
        wait_done("bad_addr_done");

        // Push and pop on the same edge while full: no error.
        do_start();
        for (int idx = 0; idx < TOTAL; idx++) begin
            y_ready = (idx == 49);
            send_idx(idx, rnd_score());
            if (idx == 49) chk("pushpop_no_err", 64'(err), 64'd0);
        end
        chk("pushpop_late_err", 64'(err), 64'd1);
        y_ready = 1'b1;
        wait_done("pushpop_done");

        // Reset mid-batch, stray beats, then a fresh randomized batch.
        do_start();
        for (int idx = 0; idx < 37; idx++) send_idx(idx, rnd_score());
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_err = 0; m_done = 0; m_exp = 0; m_armed = 0;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int idx = 0; idx < 3; idx++) send_idx(idx, rnd_score());
        chk("stray_valid", 64'(pred_valid), 64'd0);
        do_start();
        random_beats(0, 1'b1);
        wait_done("random_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mlp_result_argmax.md
Name: mlp_result_argmax

Overview:
Downstream consumer of the MLP top's output-buffer write stream. It snoops the y_buf write beats (byte address in steps of 4, one 32-bit signed score per beat, NUM_CLASS scores per image) and computes a running argmax per image. Each finished image yields one {image, class, score} result, queued in a small FIFO and drained over a valid/ready port. It also reports completion of the whole batch and any sticky protocol errors.

Parameters:
IN_IMG_NUM, 10, images per batch
NUM_CLASS, 10, scores per image
Y_BUF_DATA_WIDTH, 32, score width (two's-complement)
Y_BUF_ADDR_WIDTH, 32, byte-address width of the write stream
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
IMGW, $clog2(IN_IMG_NUM), image-index width (derived)
CLSW, $clog2(NUM_CLASS), class-index width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse: arm for a new batch
y_buf_en_i  in  1  buffer enable from MLP top
y_buf_wr_en_i  in  1  write enable from MLP top
y_buf_addr_i  in  Y_BUF_ADDR_WIDTH  byte address (index*4)
y_buf_data_i  in  Y_BUF_DATA_WIDTH  signed score
pred_valid_o  out  1  FIFO head valid
pred_ready_i  in  1  consumer accepts head
pred_img_o  out  IMGW  image index of head result
pred_class_o  out  CLSW  argmax class of head result
pred_score_o  out  Y_BUF_DATA_WIDTH  max score of head result
all_done_o  out  1  batch complete and FIFO drained (level)
err_o  out  1  sticky protocol/overflow error

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE.
- Beat = y_buf_en_i & y_buf_wr_en_i on a rising edge. index = addr>>2; expected index counter exp_idx runs 0..IN_IMG_NUM*NUM_CLASS-1; img_cnt/cls_cnt track image and class.
- States: IDLE -> (start_i) COLLECT -> (final beat of last image accepted) DRAIN -> (FIFO empty) DONE -> (start_i) COLLECT.
- start_i in IDLE/DONE: clear exp_idx, img_cnt, cls_cnt, err_o, all_done_o, FIFO. start_i in COLLECT/DRAIN ignored.
- Beats in IDLE/DRAIN/DONE ignored, no error.
- COLLECT beat check: addr[1:0]!=0 or index!=exp_idx -> err_o set (sticky), beat dropped, counters unchanged.
- Valid beat, cls_cnt==0: max<=data, argcls<=0. Otherwise signed compare; replace only if data > max (strict), so ties keep the lowest class.
- Valid beat with cls_cnt==NUM_CLASS-1: push {img_cnt, winner, winner score}, where the winner is resolved combinationally from the incoming beat against the running max. Push occurs on the same edge. pred_valid_o is high from the next cycle if the FIFO was empty: 1-cycle latency. cls_cnt wraps to 0; img_cnt increments.
- FIFO: pop on pred_valid_o & pred_ready_i. Push while full with no simultaneous pop: result dropped, err_o set. Push+pop in the same cycle while full: both proceed, no error. Outputs show the FIFO head and are held stable while pred_valid_o & !pred_ready_i.
- all_done_o is set on the edge entering DONE (FIFO empty after last push) and held until start_i or reset.
- Reset mid-batch: immediate clear to reset values; partial results are lost.
- Signed compare uses the full Y_BUF_DATA_WIDTH; no saturation.

Test Plan:
- Reset, start_i, then 100 in-order beats with pred_ready_i=1. Image k has class (k%10) score 1000+k and the others -5 -> 10 results {k, k%10, 1000+k} in order; all_done_o high once the FIFO is empty.
- Single image with scores -3,-1,-1,-7,... (all negative, tie at classes 1 and 2) -> class 1, score -1 (signed, tie keeps lowest).
- pred_ready_i=0 for the whole batch, FIFO_DEPTH=4 -> first 4 results retained, 5th push sets err_o, head stays {0,...}. Then raise ready -> 4 results drain and all_done_o asserts.
- Beat with addr=0x8 when exp_idx=1, and a beat with addr=0x6 -> err_o=1, both dropped; a following addr=0x4 beat is accepted normally.
- Full FIFO with pred_ready_i=1 on the same cycle as a push -> no err_o; occupancy stays 4.
- Assert rst_i at beat 37 -> all outputs 0 immediately. start_i plus a fresh 100 beats -> correct 10 results; beats sent before start_i are ignored.
